key_poll_master: RTL and testbench

KEY_POLL_MASTER -- requirements
Module: key_poll_master

---
 rtl/key_poll_master.sv | 106 ++++++++++
 tb/tb_key_poll_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_poll_master.sv
// Avalon-MM master that polls an active-low key input, debounces it, counts
// presses and writes the running press count to an LED port.
module key_poll_master #(
   parameter int unsigned POLL_DIV   = 50000,
   parameter int unsigned DEBOUNCE_N = 4,
   parameter logic [3:0]  KEY_ADDR   = 4'd0,
   parameter logic [3:0]  LED_ADDR   = 4'd4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic [3:0]  avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        key_level,
   output logic [7:0]  press_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_REQ  = 2'd1;
   localparam logic [1:0] RD_DATA = 2'd2;
   localparam logic [1:0] WR_REQ  = 2'd3;

   localparam int unsigned TW = $clog2(POLL_DIV);
   localparam int unsigned CW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_DIV - 1);
   localparam logic [CW-1:0] DB_LAST      = CW'(DEBOUNCE_N - 1);

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic [CW-1:0] db_cnt;
   logic [7:0]    count_inc;
   logic          sample;
   logic          unused_readdata;

   assign count_inc       = press_count + 8'd1;
   assign sample          = avm_readdata[0];
   assign unused_readdata = ^avm_readdata[31:1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         timer         <= TIMER_RELOAD;
         db_cnt        <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         key_level     <= 1'b1;
         press_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  if (timer == '0) begin
                     timer       <= TIMER_RELOAD;
                     state       <= RD_REQ;
                     avm_read    <= 1'b1;
                     avm_address <= KEY_ADDR;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
            end
            RD_REQ: begin
               if (!avm_waitrequest) begin
                  avm_read    <= 1'b0;
                  avm_address <= '0;
                  state       <= RD_DATA;
               end
            end
            RD_DATA: begin
               // Read data is valid exactly one cycle after acceptance.
               state <= IDLE;
               if (sample == key_level) begin
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  db_cnt    <= '0;
                  key_level <= sample;
                  if (!sample) begin
                     press_count   <= count_inc;
                     avm_write     <= 1'b1;
                     avm_address   <= LED_ADDR;
                     avm_writedata <= {24'b0, count_inc};
                     state         <= WR_REQ;
                  end
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            WR_REQ: begin
               if (!avm_waitrequest) begin
                  avm_write   <= 1'b0;
                  avm_address <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_poll_master.sv
// Randomized bench for key_poll_master: acts as the Avalon slave and checks
// bus activity, key_level and press_count against a sample-history model.
module tb_key_poll_master;

   localparam int unsigned POLL_DIV   = 4;
   localparam int unsigned DEBOUNCE_N = 2;
   localparam logic [3:0]  KEY_ADDR   = 4'd0;
   localparam logic [3:0]  LED_ADDR   = 4'd4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = '1;
   logic        avm_waitrequest = 1'b0;
   logic        key_level;
   logic [7:0]  press_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Model: level plus the run of samples that disagree with it.
   bit          m_level;
   int unsigned m_count;
   bit          m_run[$];

   key_poll_master #(
      .POLL_DIV(POLL_DIV),
      .DEBOUNCE_N(DEBOUNCE_N),
      .KEY_ADDR(KEY_ADDR),
      .LED_ADDR(LED_ADDR)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_write(avm_write),
      .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .key_level(key_level),
      .press_count(press_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   function automatic void model_reset();
      m_level = 1'b1;
      m_count = 0;
      m_run.delete();
   endfunction

   // Returns 1 when the sample completes a debounced press (LED write expected).
   function automatic bit model_sample(input bit s);
      if (s == m_level) begin
         m_run.delete();
         return 1'b0;
      end
      m_run.push_back(s);
      if (m_run.size() < DEBOUNCE_N) return 1'b0;
      m_run.delete();
      m_level = s;
      if (!s) begin
         m_count = (m_count + 1) % 256;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Serves one poll transaction; call at a negedge.
   task automatic run_poll(input bit key, input int unsigned rwait,
                           input int unsigned wwait, input bit abort_wr);
      logic [31:0] rd;
      logic [31:0] exp_wd;
      int unsigned guard;
      bit          stray_wr;
      bit          exp_wr;
      rd = $urandom();
      rd[0] = key;
      avm_readdata = rd;
      avm_waitrequest = (rwait > 0);
      guard = 0;
      stray_wr = 1'b0;
      while (avm_read !== 1'b1 && guard < 50) begin
         if (avm_write !== 1'b0) stray_wr = 1'b1;
         @(negedge clk);
         guard++;
      end
      checks++;
      if (avm_read !== 1'b1 || stray_wr) begin
         errors++;
         $display("FAIL poll_start: read=%b stray_write=%b after %0d cycles, expected read=1 no write",
                  avm_read, stray_wr, guard);
         return;
      end
      for (int unsigned i = 0; i <= rwait; i++) begin
         checks++;
         if (avm_read !== 1'b1 || avm_address !== KEY_ADDR || avm_write !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: cycle %0d read=%b addr=%0h write=%b, expected 1/%0h/0",
                     i, avm_read, avm_address, avm_write, KEY_ADDR);
         end
         if (i == rwait) avm_waitrequest = 1'b0;
         else @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 4'd0) begin
         errors++;
         $display("FAIL read_release: read=%b write=%b addr=%0h, expected 0/0/0",
                  avm_read, avm_write, avm_address);
      end
      exp_wr = model_sample(key);
      exp_wd = 32'(m_count);
      avm_waitrequest = (wwait > 0) || abort_wr;
      @(negedge clk);
      avm_readdata = $urandom();
      checks++;
      if (key_level !== m_level || press_count !== 8'(m_count) ||
          avm_write !== exp_wr || avm_read !== 1'b0) begin
         errors++;
         $display("FAIL sample_result: level=%b count=%0d write=%b read=%b, expected %b/%0d/%b/0",
                  key_level, press_count, avm_write, avm_read, m_level, m_count, exp_wr);
      end
      if (!(exp_wr && avm_write === 1'b1)) return;
      if (abort_wr) begin
         @(negedge clk);
         reset_n = 1'b0;
         #1;
         model_reset();
         checks++;
         if (avm_write !== 1'b0 || press_count !== 8'd0 || key_level !== 1'b1 ||
             avm_address !== 4'd0 || avm_writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: write=%b count=%0d level=%b addr=%0h wdata=%0h, expected 0/0/1/0/0",
                     avm_write, press_count, key_level, avm_address, avm_writedata);
         end
         avm_waitrequest = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
         return;
      end
      for (int unsigned i = 0; i <= wwait; i++) begin
         checks++;
         if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_address !== LED_ADDR ||
             avm_writedata !== exp_wd) begin
            errors++;
            $display("FAIL write_hold: cycle %0d write=%b read=%b addr=%0h wdata=%0h, expected 1/0/%0h/%0h",
                     i, avm_write, avm_read, avm_address, avm_writedata, LED_ADDR, exp_wd);
         end
         if (i == wwait) avm_waitrequest = 1'b0;
         else @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (avm_write !== 1'b0 || avm_address !== 4'd0 || avm_writedata !== exp_wd) begin
         errors++;
         $display("FAIL write_release: write=%b addr=%0h wdata=%0h, expected 0/0/%0h",
                  avm_write, avm_address, avm_writedata, exp_wd);
      end
   endtask

   task automatic ensure_released();
      for (int k = 0; k < 4 && m_level == 1'b0; k++) run_poll(1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b1;
      avm_waitrequest = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 4'd0 ||
          avm_writedata !== 32'd0 || key_level !== 1'b1 || press_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: read=%b write=%b addr=%0h wdata=%0h level=%b count=%0d",
                  avm_read, avm_write, avm_address, avm_writedata, key_level, press_count);
      end
      reset_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         checks++;
         if (e < 4 && (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 4'd0)) begin
            errors++;
            $display("FAIL first_poll_early: edge %0d read=%b write=%b addr=%0h, expected 0/0/0",
                     e, avm_read, avm_write, avm_address);
         end
         if (e == 4 && (avm_read !== 1'b1 || avm_address !== KEY_ADDR)) begin
            errors++;
            $display("FAIL first_poll_edge4: read=%b addr=%0h, expected 1/%0h",
                     avm_read, avm_address, KEY_ADDR);
         end
      end
      run_poll(1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_read_wait();
      run_poll(1'b1, 3, 0, 1'b0);
      run_poll(1'b0, 3, 0, 1'b0);
      run_poll(1'b1, 1, 0, 1'b0);
   endtask

   task automatic test_bounce();
      ensure_released();
      run_poll(1'b1, 0, 0, 1'b0);
      run_poll(1'b0, 0, 0, 1'b0);
      run_poll(1'b1, 0, 0, 1'b0);
      run_poll(1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_press_release();
      ensure_released();
      run_poll(1'b0, 0, 0, 1'b0);
      run_poll(1'b0, 1, 2, 1'b0);
      run_poll(1'b1, 0, 0, 1'b0);
      run_poll(1'b1, 2, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++)
         run_poll(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
   endtask

   task automatic test_enable();
      int unsigned guard;
      bit          stray;
      guard = 0;
      while (avm_read !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      enable = 1'b0;
      run_poll(m_level ? 1'b0 : 1'b1, 2, 1, 1'b0);
      stray = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (avm_read !== 1'b0 || avm_write !== 1'b0) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL enable_low: bus activity seen while disabled, expected none");
      end
      enable = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         checks++;
         if (avm_read !== (e == 4)) begin
            errors++;
            $display("FAIL enable_resume: edge %0d read=%b, expected %b", e, avm_read, e == 4);
         end
      end
      run_poll(1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_wrap();
      int unsigned guard;
      ensure_released();
      guard = 0;
      while (m_count != 255 && guard < 300) begin
         run_poll(1'b0, 0, 0, 1'b0);
         run_poll(1'b0, 0, 0, 1'b0);
         run_poll(1'b1, 0, 0, 1'b0);
         run_poll(1'b1, 0, 0, 1'b0);
         guard++;
      end
      run_poll(1'b0, 0, 0, 1'b0);
      run_poll(1'b0, 0, 1, 1'b0);
      checks++;
      if (press_count !== 8'd0 || avm_writedata !== 32'd0) begin
         errors++;
         $display("FAIL count_wrap: count=%0d wdata=%0h, expected 0/0", press_count, avm_writedata);
      end
      run_poll(1'b1, 0, 0, 1'b0);
      run_poll(1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_reset_during_write();
      ensure_released();
      run_poll(1'b0, 0, 0, 1'b0);
      run_poll(1'b0, 0, 0, 1'b1);
      run_poll(1'b1, 0, 0, 1'b0);
      run_poll(1'b1, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_read_wait();
      test_bounce();
      test_press_release();
      test_random();
      test_enable();
      test_wrap();
      test_reset_during_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
